// File: rtl/counting_down_display_pkg.sv
// counting_down_pkg: FSM states, display limit and active-low seven-segment patterns shared by the timer
package counting_down_pkg;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;
  localparam logic [13:0] MAX_DISPLAY = 14'd9999;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [9:0][6:0] SEG_LUT = {
    7'b0010000, 7'b0000000, 7'b1111000, 7'b0000010, 7'b0010010,
    7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };
  function automatic logic [7:0] seg_of(input logic [3:0] d);
    return d > 4'd9 ? SEG_BLANK : {1'b1, SEG_LUT[d]};
  endfunction
endpackage

// File: rtl/counting_down_display_if.sv
// counting_down_display_if: time_in/start from control (master), stop/seg/an back from the timer (slave)
interface counting_down_display_if;
  logic [15:0] time_in;
  logic start;
  logic stop;
  logic [7:0] seg;
  logic [3:0] an;
  modport master(output time_in, start, input stop, seg, an);
  modport slave(input time_in, start, output stop, seg, an);
endinterface

// File: rtl/counting_down_display_seven_seg_scan.sv
// seven_seg_scan: bcd_i four digits in, seg_o/an_o active-low multiplexed drive, digit held REFRESH_CYCLES clocks
module seven_seg_scan
  import counting_down_pkg::*;
#(
  parameter int REFRESH_CYCLES = 100_000
) (
  input  logic clk,
  input  logic rst,
  input  logic [3:0][3:0] bcd_i,
  output logic [7:0] seg_o,
  output logic [3:0] an_o
);
  localparam int RW = REFRESH_CYCLES > 1 ? $clog2(REFRESH_CYCLES) : 1;
  localparam logic [RW-1:0] RC_MAX = RW'(REFRESH_CYCLES - 1);
  logic [RW-1:0] rc_q, rc_d;
  logic [1:0] idx_q, idx_d;
  always_comb begin
    rc_d = rc_q == RC_MAX ? '0 : rc_q + 1'b1;
    idx_d = rc_q == RC_MAX ? idx_q + 1'b1 : idx_q;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rc_q <= '0;
      idx_q <= '0;
    end else begin
      rc_q <= rc_d;
      idx_q <= idx_d;
    end
  end
  assign an_o = ~(4'b0001 << idx_q);
  assign seg_o = seg_of(bcd_i[idx_q]);
endmodule

// File: rtl/counting_down_display.sv
// counting_down_display: clk/rst plus io slave (time_in,start in; stop,seg,an out) seconds countdown with 4-digit readout
module counting_down_display
  import counting_down_pkg::*;
#(
  parameter int TICKS_PER_SEC = 100_000_000,
  parameter int REFRESH_CYCLES = 100_000
) (
  input logic clk,
  input logic rst,
  counting_down_display_if.slave io
);
  localparam int PW = TICKS_PER_SEC > 1 ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(TICKS_PER_SEC - 1);
  state_e state_q, state_d;
  logic start_q, stop_q, stop_d, start_rise, wrap;
  logic [13:0] rem_q, rem_d, load_val;
  logic [PW-1:0] pre_q, pre_d;
  assign start_rise = io.start & ~start_q;
  assign load_val = io.time_in > 16'(MAX_DISPLAY) ? MAX_DISPLAY : io.time_in[13:0];
  assign wrap = pre_q == PRE_MAX;
  // a load always takes priority over a same-cycle prescaler wrap
  always_comb begin
    state_d = state_q;
    rem_d = rem_q;
    pre_d = pre_q;
    stop_d = stop_q;
    if (start_rise) begin
      rem_d = load_val;
      pre_d = '0;
      stop_d = load_val == '0;
      state_d = load_val == '0 ? DONE : RUN;
    end else if (state_q == RUN) begin
      pre_d = wrap ? '0 : pre_q + 1'b1;
      rem_d = wrap ? rem_q - 1'b1 : rem_q;
      stop_d = wrap && rem_q == 14'd1;
      state_d = wrap && rem_q == 14'd1 ? DONE : RUN;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      start_q <= 1'b0;
      stop_q <= 1'b0;
      rem_q <= '0;
      pre_q <= '0;
    end else begin
      state_q <= state_d;
      start_q <= io.start;
      stop_q <= stop_d;
      rem_q <= rem_d;
      pre_q <= pre_d;
    end
  end
  assign io.stop = stop_q;
  seven_seg_scan #(.REFRESH_CYCLES(REFRESH_CYCLES)) u_scan (
    .clk(clk),
    .rst(rst),
    .bcd_i({4'(rem_q / 14'd1000), 4'((rem_q / 14'd100) % 14'd10), 4'((rem_q / 14'd10) % 14'd10), 4'(rem_q % 14'd10)}),
    .seg_o(io.seg),
    .an_o(io.an)
  );
endmodule

// File: tb/tb_counting_down_display.sv
// tb_counting_down_display: directed checks of load, countdown timing, stop level, reset, clamp and display scan
module tb_counting_down_display;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;
  counting_down_display_if io();
  counting_down_display #(.TICKS_PER_SEC(10), .REFRESH_CYCLES(2)) dut (.clk(clk), .rst(rst), .io(io));
  localparam logic [6:0] PAT [10] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
    7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
  };
  int n_cmp = 0;
  int n_bad = 0;
  int jj = 0;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(negedge clk);
    jj++;
  endtask
  task automatic go_to(input int j);
    while (jj < j) step();
  endtask
  task automatic load(input logic [15:0] v, input int hold);
    io.time_in = v;
    io.start = 1'b1;
    @(negedge clk);
    jj = 0;
    repeat (hold - 1) step();
    io.start = 1'b0;
  endtask
  task automatic check_disp(input int v, input string tag);
    int d;
    for (int k = 0; k < 8; k++) begin
      case (io.an)
        4'b1110: d = v % 10;
        4'b1101: d = (v / 10) % 10;
        4'b1011: d = (v / 100) % 10;
        4'b0111: d = v / 1000;
        default: d = -1;
      endcase
      chk({tag, "_an_onehot"}, 32'(d >= 0), 32'd1);
      if (d >= 0) chk({tag, "_seg"}, io.seg, {1'b1, PAT[d]});
      step();
    end
  endtask
  initial begin
    logic [3:0] an_exp;
    io.time_in = '0;
    io.start = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_stop", io.stop, 0);
    for (int k = 0; k < 8; k++) begin
      an_exp = ~(4'b0001 << (k / 2));
      chk("rst_an", io.an, an_exp);
      chk("rst_seg", io.seg, 8'hC0);
      @(negedge clk);
    end
    load(16'd5, 2);
    for (int v = 5; v >= 1; v--) begin
      go_to(10 * (5 - v));
      chk("t5_stop_run", io.stop, 0);
      check_disp(v, "t5_disp");
    end
    go_to(49);
    chk("t5_stop_before", io.stop, 0);
    go_to(50);
    chk("t5_stop_rise", io.stop, 1);
    check_disp(0, "t5_zero");
    go_to(70);
    chk("t5_stop_hold", io.stop, 1);
    load(16'd3, 1);
    chk("t3_stop_drop", io.stop, 0);
    for (int v = 3; v >= 1; v--) begin
      go_to(10 * (3 - v));
      check_disp(v, "t3_disp");
    end
    go_to(29);
    chk("t3_stop_before", io.stop, 0);
    go_to(30);
    chk("t3_stop_rise", io.stop, 1);
    check_disp(0, "t3_zero");
    load(16'd10, 1);
    go_to(20);
    check_disp(8, "t10_disp8");
    rst = 1'b1;
    #1;
    chk("rst_mid_stop", io.stop, 0);
    chk("rst_mid_an", io.an, 4'b1110);
    chk("rst_mid_seg", io.seg, 8'hC0);
    repeat (5) @(negedge clk);
    rst = 1'b0;
    chk("rst_rel_stop", io.stop, 0);
    check_disp(0, "rst_rel_disp");
    repeat (30) @(negedge clk);
    chk("rst_idle_stop", io.stop, 0);
    check_disp(0, "rst_idle_disp");
    load(16'd0, 1);
    chk("t0_stop", io.stop, 1);
    check_disp(0, "t0_disp");
    load(16'd12345, 1);
    chk("clamp_stop", io.stop, 0);
    check_disp(9999, "clamp_disp");
    load(16'd7, 1);
    go_to(25);
    chk("restart_stop_run", io.stop, 0);
    load(16'd2, 1);
    check_disp(2, "restart_disp");
    go_to(19);
    chk("restart_stop_before", io.stop, 0);
    go_to(20);
    chk("restart_stop_rise", io.stop, 1);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/counting_down_display.md
Name: counting_down_display

Overview:
- Loadable seconds countdown timer with a 4-digit multiplexed seven-segment readout.
- A start pulse loads a seconds value and counts it down to zero at one count per second.
- At zero it asserts a completion level, `stop`.
- Sits between control logic that sets durations and the board's 4-digit common-anode display.

Parameters:
- TICKS_PER_SEC, 100_000_000: clk cycles per one-second decrement. Simulation uses a small value, e.g. 10.
- REFRESH_CYCLES, 100_000: clk cycles each digit stays enabled during display scanning. Must be ≥ 1.

Ports:
- clk  input  1  system clock, single clock domain.
- rst  input  1  reset. One clock; reset is asynchronous and active-high.
- time_in  input  16  countdown start value in seconds, unsigned. Sampled on start.
- start  input  1  load/launch request. Rising-edge detected internally.
- stop  output  1  high while countdown has completed. Level signal.
- seg  output  8  active-low segments: seg[0]=a … seg[6]=g, seg[7]=dp. dp is always off (1).
- an  output  4  active-low digit enables: an[0]=units … an[3]=thousands.

Behaviour:
- Reset (asynchronous, while rst=1):
  - state=IDLE, remaining=0, prescaler=0, stop=0.
  - start edge-detect register=0, scan index=0.
  - an=4'b1110, seg shows "0" on units (8'b1100_0000).
- States: IDLE, RUN, DONE.
- Start edge: `start_q` registers start. `start_rise = start & ~start_q`. Held-high start is a single event.
- Load, in any state:
  - On start_rise: remaining <= min(time_in, 9999); prescaler <= 0; stop <= 0.
  - Next state is RUN if the loaded value > 0, else DONE (stop=1 from the next cycle).
  - A start during RUN restarts with the new value.
- RUN:
  - prescaler counts 0..TICKS_PER_SEC-1, then wraps.
  - On wrap, remaining decrements.
  - If remaining was 1, it becomes 0, state → DONE and stop → 1 on the same edge.
  - With value N loaded at edge L, stop rises at edge L + N·TICKS_PER_SEC.
- DONE:
  - remaining=0 and stop=1.
  - Held until the next start_rise (load) or reset. No decrement, no wrap below zero.
- Simultaneous start_rise and prescaler wrap: load wins.
- Reset mid-RUN: immediate return to IDLE, stop=0, display 0000.
- Display:
  - remaining (0..9999) is converted to 4 BCD digits, combinationally or registered within 1 cycle.
  - Leading zeros are displayed.
  - Scan counter advances the digit index every REFRESH_CYCLES cycles: 0→1→2→3→0.
  - an is one-hot-low on the index. seg is the decoded pattern for that digit.
  - Scanning runs continuously in all states.
- Digit patterns, active-low {g..a}:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000

Decomposition:
- Package counting_down_pkg holds:
  - state enum {IDLE, RUN, DONE}.
  - constant MAX_DISPLAY=9999.
  - 10-entry seven-segment pattern constant / digit-to-seg function.
  - SEG_BLANK constant = 8'hFF.
- One sub-module, seven_seg_scan, parameterised by REFRESH_CYCLES:
  - Inputs: 4×4-bit BCD digits. Outputs: seg and an.
  - Contains the refresh counter, digit mux and decoder.
- Top contains the edge detect, FSM, prescaler, remaining counter and binary-to-BCD conversion.

Test Plan (TICKS_PER_SEC=10, REFRESH_CYCLES=2, 10 ns clk):
- Reset → stop=0; an cycles 1110,1101,1011,0111; seg=11000000 on every digit.
- time_in=5, start high 2 cycles:
  - remaining 5,4,3,2,1,0 at 10-cycle steps.
  - stop rises exactly 50 cycles after the load edge and stays 1.
- After DONE, time_in=3 with start pulse:
  - stop drops the cycle after load.
  - stop re-rises 30 cycles later. Units digit shows 3→2→1→0.
- time_in=10, start, wait 20 cycles → remaining=8. Assert rst for 5 cycles:
  - stop=0, display 0000, no further counting after release.
- time_in=0 with start → stop=1 on the next cycle. time_in=12345 with start → display 9999.
- Mid-RUN restart: load 7, after 25 cycles load 2 → stop rises 20 cycles after the second load.
